fb_rect_fill: RTL and testbench
===============================

Name: fb_rect_fill

Overview:
Framebuffer writer: accepts rectangle-fill commands and writes pixels into the dual-port framebuffer RAM through its write port (port A), one pixel per clock.
- The VGA scan-out path reads the same RAM through port B; this block is the producer at the other end of that buffer.
- Rectangles are clipped to the screen and written in row-major order.
- Addresses are linear: y*H_RES + x.

Parameters:
H_RES, 640, horizontal resolution in pixels
V_RES, 480, vertical resolution in lines
ADDR_W, 19, framebuffer address width
DATA_W, 16, pixel word width
X_W, 10, width of x coordinate/width fields
Y_W, 9, width of y coordinate/height fields

Ports:
clk  in  1  system clock; single clock domain, shared with RAM port A
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command; high only in IDLE
cmd_x  in  X_W  left column
cmd_y  in  Y_W  top row
cmd_w  in  X_W  width in pixels
cmd_h  in  Y_W  height in lines
cmd_color  in  DATA_W  fill value
cmd_outline  in  1  outline-only request; honoured only with FB_OUTLINE_EN
busy  out  1  command in progress (any state other than IDLE)
done  out  1  one-cycle pulse when a command completes
wea  out  1  RAM write enable
addra  out  ADDR_W  RAM write address
dina  out  DATA_W  RAM write data

Behaviour:
- Reset (asynchronous, rstn=0): state=IDLE, busy=0, done=0, wea=0, addra=0, dina=0, all internal registers 0. cmd_ready=1 once in IDLE.
- States: IDLE, LOAD, FILL, DONE.
- IDLE: handshake completes when cmd_valid&cmd_ready at a rising edge (cycle T). All cmd_* fields are latched at T.
- Clipping, computed in X_W+1 / Y_W+1 bits:
  - xe = min(cmd_x+cmd_w, H_RES)
  - ye = min(cmd_y+cmd_h, V_RES)
  - Empty case: cmd_w==0, cmd_h==0, cmd_x>=H_RES or cmd_y>=V_RES. Next state is DONE; no writes occur.
  - Otherwise next state is LOAD.
- LOAD (cycle T+1): row_base = cmd_y*H_RES (ADDR_W bits); x=cmd_x, y=cmd_y. Next state is FILL.
- FILL: wea, addra and dina are registered outputs.
  - Each cycle: wea=1, addra=row_base+x, dina=latched color.
  - If x<xe-1: x++.
  - Else x=cmd_x, y++, row_base+=H_RES (adder, no multiply).
  - After the write at (xe-1, ye-1), next state is DONE.
  - First write is visible at cycle T+2. N clipped pixels occupy cycles T+2..T+1+N.
- DONE: done=1 and wea=0 for exactly one cycle, then IDLE.
  - Empty command: done at T+1.
  - Non-empty command: done at T+2+N.
- wea=0 in every state except FILL. addra/dina hold their last values when wea=0.
- cmd_valid is ignored while busy; a held cmd_valid is accepted in the first IDLE cycle after done.
- Reset mid-FILL: wea drops to 0 immediately (asynchronously). The command is abandoned, with no done pulse. Pixels already written remain in RAM.
- Arithmetic: addra never exceeds H_RES*V_RES-1, guaranteed by clipping. No wrap-around writes.

Optional Feature:
FB_OUTLINE_EN
- Defined: a command latched with cmd_outline=1 writes only the clipped rectangle's border.
  - Rows y==cmd_y and y==ye-1 are written in full.
  - Interior rows write x=cmd_x, then jump directly to x=xe-1, giving 2 cycles per row (1 if the clipped width is 1).
  - Write order stays row-major. done timing follows the reduced write count.
- Undefined: cmd_outline is ignored (treated as 0); all rectangles are solid.

Test Plan:
- Reset: hold rstn=0 with cmd_valid=1 -> wea=0, addra=0, dina=0, done=0, busy=0; cmd_ready=1 after release with no spurious writes.
- Solid fill: x=2, y=1, w=3, h=2, color=0x0F00 accepted at T -> writes 642, 643, 644, 1282, 1283, 1284 in cycles T+2..T+7, all with dina=0x0F00; done=1 at T+8 only; busy high T+1..T+8.
- Clipping: x=638, y=479, w=5, h=4 -> exactly two writes, 307198 then 307199; done at T+4. Also x=640, w=10 -> no writes, done at T+1.
- Back-to-back and zero size: w=0 -> done at T+1 with no wea. cmd_valid held for a second command during a fill -> cmd_ready=0 throughout; second command accepted the cycle after done.
- Reset mid-fill: 10x10 fill, rstn pulsed low after 15 writes -> wea=0 immediately, no done; a following 1x1 command at (0,0) writes addr 0 and pulses done.
- FB_OUTLINE_EN: x=0, y=0, w=3, h=3, cmd_outline=1 -> writes 0, 1, 2, 640, 642, 1280, 1281, 1282 in consecutive cycles; done at T+10. Same command without the macro -> 9 writes.

Source files
------------

// File: rtl/fb_rect_fill.sv
// Rectangle-fill framebuffer writer: clips a rectangle to the screen and writes it row-major
// through RAM port A, one pixel per clock. Define FB_OUTLINE_EN to honour cmd_outline.
module fb_rect_fill #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned X_W    = 10,
  parameter int unsigned Y_W    = 9
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [X_W-1:0]    cmd_x,
  input  logic [Y_W-1:0]    cmd_y,
  input  logic [X_W-1:0]    cmd_w,
  input  logic [Y_W-1:0]    cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  input  logic              cmd_outline,
  output logic              busy,
  output logic              done,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina
);

  localparam logic [X_W:0]      HResX = (X_W+1)'(H_RES);
  localparam logic [Y_W:0]      VResY = (Y_W+1)'(V_RES);
  localparam logic [ADDR_W-1:0] HResA = ADDR_W'(H_RES);
  localparam logic [X_W:0]      OneX  = (X_W+1)'(1);
  localparam logic [Y_W:0]      OneY  = (Y_W+1)'(1);
  localparam logic [X_W-1:0]    IncX  = X_W'(1);
  localparam logic [Y_W-1:0]    IncY  = Y_W'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StFill, StDone} state_e;

  state_e              state_q, state_d;
  logic [X_W-1:0]      x0_q, x0_d;
  logic [Y_W-1:0]      y0_q, y0_d;
  logic [X_W:0]        xe_q, xe_d;
  logic [Y_W:0]        ye_q, ye_d;
  logic [DATA_W-1:0]   color_q, color_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic                wea_q, wea_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [DATA_W-1:0]   dina_q, dina_d;

  logic                outline_cmd;
  logic                interior;
`ifdef FB_OUTLINE_EN
  logic                outline_q, outline_d;
  assign outline_cmd = cmd_outline;
`else
  logic                unused_outline;
  assign unused_outline = cmd_outline;
  assign outline_cmd    = 1'b0;
`endif

  // Clipping of the incoming command, evaluated in the handshake cycle.
  logic [X_W:0] x_sum, xe_c;
  logic [Y_W:0] y_sum, ye_c;
  logic         cmd_empty;

  always_comb begin
    x_sum     = {1'b0, cmd_x} + {1'b0, cmd_w};
    y_sum     = {1'b0, cmd_y} + {1'b0, cmd_h};
    xe_c      = (x_sum > HResX) ? HResX : x_sum;
    ye_c      = (y_sum > VResY) ? VResY : y_sum;
    cmd_empty = (cmd_w == '0) || (cmd_h == '0) ||
                ({1'b0, cmd_x} >= HResX) || ({1'b0, cmd_y} >= VResY);
  end

  // Pixel walk: where the write after the current one lands.
  logic                x_last, y_last, last_px;
  logic [X_W-1:0]      x_nxt;
  logic [Y_W-1:0]      y_nxt;
  logic [ADDR_W-1:0]   rb_nxt;
  logic [ADDR_W-1:0]   load_base;

  always_comb begin
    x_last  = (({1'b0, x_q} + OneX) == xe_q);
    y_last  = (({1'b0, y_q} + OneY) == ye_q);
    last_px = x_last && y_last;
`ifdef FB_OUTLINE_EN
    interior = outline_q && (y_q != y0_q) && !y_last;
`else
    interior = 1'b0;
`endif
    if (!x_last) begin
      // Interior outline rows skip straight from the left edge to the right edge.
      x_nxt  = (interior && (x_q == x0_q)) ? X_W'(xe_q - OneX) : x_q + IncX;
      y_nxt  = y_q;
      rb_nxt = row_base_q;
    end else begin
      x_nxt  = x0_q;
      y_nxt  = y_q + IncY;
      rb_nxt = row_base_q + HResA;
    end
    load_base = ADDR_W'(y0_q) * HResA;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_valid) state_d = cmd_empty ? StDone : StLoad;
      StLoad:  state_d = StFill;
      StFill:  if (last_px) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state logic.
  always_comb begin
    x0_d       = x0_q;
    y0_d       = y0_q;
    xe_d       = xe_q;
    ye_d       = ye_q;
    color_d    = color_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    wea_d      = 1'b0;
    addra_d    = addra_q;
    dina_d     = dina_q;
`ifdef FB_OUTLINE_EN
    outline_d  = outline_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          x0_d    = cmd_x;
          y0_d    = cmd_y;
          xe_d    = xe_c;
          ye_d    = ye_c;
          color_d = cmd_color;
`ifdef FB_OUTLINE_EN
          outline_d = outline_cmd;
`endif
        end
      end
      StLoad: begin
        x_d        = x0_q;
        y_d        = y0_q;
        row_base_d = load_base;
        wea_d      = 1'b1;
        addra_d    = load_base + ADDR_W'(x0_q);
        dina_d     = color_q;
      end
      StFill: begin
        if (!last_px) begin
          x_d        = x_nxt;
          y_d        = y_nxt;
          row_base_d = rb_nxt;
          wea_d      = 1'b1;
          addra_d    = rb_nxt + ADDR_W'(x_nxt);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      x0_q       <= '0;
      y0_q       <= '0;
      xe_q       <= '0;
      ye_q       <= '0;
      color_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      dina_q     <= '0;
`ifdef FB_OUTLINE_EN
      outline_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      xe_q       <= xe_d;
      ye_q       <= ye_d;
      color_q    <= color_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
`ifdef FB_OUTLINE_EN
      outline_q  <= outline_d;
`endif
    end
  end

  // Output decode.
  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    wea       = wea_q;
    addra     = addra_q;
    dina      = dina_q;
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: a reference pixel walk fills a scoreboard of expected
// writes and done pulses, which a negedge monitor pops and checks.
module tb_fb_rect_fill;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [9:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [15:0] cmd_color;
  logic        cmd_outline;
  logic        busy;
  logic        done;
  logic        wea;
  logic [18:0] addra;
  logic [15:0] dina;

  fb_rect_fill dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_w       (cmd_w),
    .cmd_h       (cmd_h),
    .cmd_color   (cmd_color),
    .cmd_outline (cmd_outline),
    .busy        (busy),
    .done        (done),
    .wea         (wea),
    .addra       (addra),
    .dina        (dina)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t sb_q[$];
  int  done_q[$];
  int  n_cmp  = 0;
  int  n_mis  = 0;
  int  cyc    = 0;
  int  wr_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: enumerate clipped pixels row-major, keep border only for outlines.
  task automatic push_cmd(input int x, input int y, input int w, input int h, input int c,
                          input bit o, input int t);
    int xe;
    int ye;
    int k;
    k  = 0;
    xe = (x + w > 640) ? 640 : x + w;
    ye = (y + h > 480) ? 480 : y + h;
    if (w == 0 || h == 0 || x >= 640 || y >= 480) begin
      done_q.push_back(t);
      return;
    end
    for (int yy = y; yy < ye; yy++) begin
      for (int xx = x; xx < xe; xx++) begin
        bit keep;
        keep = 1'b1;
`ifdef FB_OUTLINE_EN
        if (o && yy != y && yy != ye - 1 && xx != x && xx != xe - 1) keep = 1'b0;
`else
        if (o) keep = 1'b1;
`endif
        if (keep) begin
          sb_q.push_back('{addr: yy * 640 + xx, data: c, cyc: t + 1 + k});
          k++;
        end
      end
    end
    done_q.push_back(t + 1 + k);
  endtask

  always @(negedge clk) begin
    wr_t e;
    int  d;
    if (rstn) begin
      if (wea) begin
        wr_cnt++;
        check("write_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("wr_addr", 32'(addra), e.addr);
          check("wr_data", 32'(dina), e.data);
          check("wr_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        check("done_expected", 32'(done_q.size() != 0), 32'd1);
        check("done_no_wea", 32'(wea), 32'd0);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          check("done_cycle", cyc, d);
        end
      end
    end
  end

  task automatic accept(input int x, input int y, input int w, input int h, input int c,
                        input bit o, input bit keep, output int t);
    @(negedge clk);
    cmd_x       = 10'(x);
    cmd_y       = 9'(y);
    cmd_w       = 10'(w);
    cmd_h       = 9'(h);
    cmd_color   = 16'(c);
    cmd_outline = o;
    cmd_valid   = 1'b1;
    t = -1;
    for (int i = 0; i < 2000; i++) begin
      if (cmd_ready) begin
        t = 0;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) begin
      check("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    t = cyc;
    if (!keep) cmd_valid = 1'b0;
    push_cmd(x, y, w, h, c, o, t);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && done_q.size() == 0 && !busy) break;
    end
    check("drain_writes", sb_q.size(), 0);
    check("drain_done", done_q.size(), 0);
    check("idle_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int t;
    int t_b;
    int first_ready;
    int base;

    // Reset held with a valid command present.
    rstn        = 1'b0;
    cmd_valid   = 1'b1;
    cmd_x       = 10'd5;
    cmd_y       = 9'd5;
    cmd_w       = 10'd3;
    cmd_h       = 9'd3;
    cmd_color   = 16'hFFFF;
    cmd_outline = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wea", 32'(wea), 32'd0);
    check("rst_addra", 32'(addra), 32'd0);
    check("rst_dina", 32'(dina), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    cmd_valid = 1'b0;
    rstn      = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_wea", 32'(wea), 32'd0);

    // Solid 3x2 fill with busy tracking.
    accept(2, 1, 3, 2, 16'h0F00, 1'b0, 1'b0, t);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("solid_busy", 32'(busy), 32'd1);
      check("solid_ready", 32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    check("solid_busy_end", 32'(busy), 32'd0);
    wait_idle();

    // Clipping at the bottom-right corner, then fully off-screen.
    accept(638, 479, 5, 4, 16'h1234, 1'b0, 1'b0, t);
    wait_idle();
    accept(640, 0, 10, 2, 16'h2222, 1'b0, 1'b0, t);
    wait_idle();
    accept(7, 7, 0, 5, 16'h3333, 1'b0, 1'b0, t);
    wait_idle();

    // Back-to-back: second command held on cmd_valid during the first fill.
    accept(10, 10, 2, 2, 16'hAAAA, 1'b0, 1'b1, t);
    cmd_x     = 10'd100;
    cmd_y     = 9'd200;
    cmd_w     = 10'd3;
    cmd_h     = 9'd1;
    cmd_color = 16'h5555;
    first_ready = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        first_ready = cyc;
        break;
      end
      check("held_busy", 32'(busy), 32'd1);
    end
    check("held_ready_cycle", first_ready, t + 6);
    @(posedge clk);
    #1;
    t_b       = cyc;
    cmd_valid = 1'b0;
    check("held_accept_cycle", t_b, t + 7);
    push_cmd(100, 200, 3, 1, 16'h5555, 1'b0, t_b);
    wait_idle();

    // Reset in the middle of a 10x10 fill.
    base = wr_cnt;
    accept(20, 30, 10, 10, 16'h7777, 1'b0, 1'b0, t);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (wr_cnt >= base + 15) break;
    end
    check("midfill_writes", wr_cnt - base, 15);
    rstn = 1'b0;
    #1;
    check("midfill_wea", 32'(wea), 32'd0);
    check("midfill_done", 32'(done), 32'd0);
    check("midfill_busy", 32'(busy), 32'd0);
    sb_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    accept(0, 0, 1, 1, 16'hBEEF, 1'b0, 1'b0, t);
    wait_idle();

    // Outline request: border only when the feature is built in, solid otherwise.
    accept(0, 0, 3, 3, 16'h00F0, 1'b1, 1'b0, t);
    wait_idle();

    repeat (3) @(negedge clk);
    check("final_sb_empty", sb_q.size(), 0);
    check("final_done_empty", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
